// File: rtl/pt_validate.sv
`default_nettype none
// ============================================================================
// Module   : pt_validate
// Purpose  : Checks that a length-prefixed plaintext in pt RAM is printable.
// Revision : 1.0
// ============================================================================
module pt_validate #(
   parameter logic [7:0] LO_CHAR = 8'h20,
   parameter logic [7:0] HI_CHAR = 8'h7E
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic       rdy,
   output logic [7:0] pt_addr,
   input  logic [7:0] pt_rddata,
   output logic       done,
   output logic       valid
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RD_LEN    = 3'd1,
      WAIT_LEN  = 3'd2,
      RD_BYTE   = 3'd3,
      WAIT_BYTE = 3'd4,
      DONE      = 3'd5
   } state_t;

   state_t     r_state;
   logic [7:0] r_len;
   logic [7:0] r_idx;
   logic [7:0] r_pt_addr;
   logic       r_rdy;
   logic       r_done;
   logic       r_valid;
   logic       w_in_range;

   assign w_in_range = (pt_rddata >= LO_CHAR) && (pt_rddata <= HI_CHAR);

   assign rdy     = r_rdy;
   assign done    = r_done;
   assign valid   = r_valid;
   assign pt_addr = r_pt_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_len     <= 8'd0;
         r_idx     <= 8'd0;
         r_pt_addr <= 8'd0;
         r_rdy     <= 1'b1;
         r_done    <= 1'b0;
         r_valid   <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               // done/valid stay held until the next accepted start
               if (en) begin
                  r_state   <= RD_LEN;
                  r_rdy     <= 1'b0;
                  r_done    <= 1'b0;
                  r_valid   <= 1'b0;
                  r_pt_addr <= 8'd0;
                  r_idx     <= 8'd0;
               end
            end
            RD_LEN: begin
               r_state <= WAIT_LEN;
            end
            WAIT_LEN: begin
               r_len <= pt_rddata;
               if (pt_rddata == 8'd0) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                  r_rdy   <= 1'b1;
                  r_valid <= 1'b1;
               end else begin
                  r_idx     <= 8'd1;
                  r_pt_addr <= 8'd1;
                  r_state   <= RD_BYTE;
               end
            end
            RD_BYTE: begin
               r_state <= WAIT_BYTE;
            end
            WAIT_BYTE: begin
               // idx==len terminates before idx can wrap past 255
               if (!w_in_range) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                  r_rdy   <= 1'b1;
                  r_valid <= 1'b0;
               end else if (r_idx == r_len) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                  r_rdy   <= 1'b1;
                  r_valid <= 1'b1;
               end else begin
                  r_idx     <= r_idx + 8'd1;
                  r_pt_addr <= r_idx + 8'd1;
                  r_state   <= RD_BYTE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_rdy   <= 1'b1;
               r_done  <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pt_validate.sv
`default_nettype none
// ============================================================================
// Module   : tb_pt_validate
// Purpose  : Scoreboard bench for pt_validate with directed plaintext vectors.
// Revision : 1.0
// ============================================================================
module tb_pt_validate;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       rdy;
   logic       done;
   logic       valid;
   logic [7:0] pt_addr;
   logic [7:0] pt_rddata;

   logic [7:0] mem [0:255];
   int         cyc = 0;

   typedef struct {
      logic exp_valid;
      int   done_edge;
      int   max_addr;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic prev_done;
   logic prev_rdy;
   int   max_seen;
   exp_t e;
   int   e0;

   pt_validate #(.LO_CHAR(8'h20), .HI_CHAR(8'h7E)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .rdy       (rdy),
      .pt_addr   (pt_addr),
      .pt_rddata (pt_rddata),
      .done      (done),
      .valid     (valid)
   );

   always #5 clk = ~clk;

   // synchronous-read pt RAM
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      pt_rddata <= mem[pt_addr];
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'hAA;
   endtask

   // k = number of message bytes that get read before done
   task automatic start_run(input logic exp_valid, input int k, input int max_addr,
                            input bit expect_done);
      @(negedge clk);
      en = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b0;
      e0 = cyc;
      if (expect_done) exp_q.push_back('{exp_valid, e0 + 2*k + 2, max_addr});
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 700) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("done_timeout", 0, 1);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b1;
      en    = 1'b0;
      clear_mem();

      fork
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               prev_done = 1'b0;
               prev_rdy  = 1'b1;
            end else begin
               if (prev_rdy && !rdy) max_seen = int'(pt_addr);
               else if (int'(pt_addr) > max_seen) max_seen = int'(pt_addr);
               if (done && !prev_done) begin
                  if (exp_q.size() == 0) begin
                     chk("unexpected_done", 1, 0);
                  end else begin
                     e = exp_q.pop_front();
                     chk("valid", int'(valid), int'(e.exp_valid));
                     chk("done_edge", cyc, e.done_edge);
                     chk("max_addr", max_seen, e.max_addr);
                     chk("rdy_at_done", int'(rdy), 1);
                  end
               end
               prev_done = done;
               prev_rdy  = rdy;
            end
         end
      join_none

      #1 rst_n = 1'b0;
      #2;
      chk("rst_rdy", int'(rdy), 1);
      chk("rst_done", int'(done), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_addr", int'(pt_addr), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // empty message
      mem[0] = 8'h00;
      start_run(1'b1, 0, 0, 1'b1);
      wait_done();

      // "Hi"
      mem[0] = 8'h02; mem[1] = 8'h48; mem[2] = 8'h69;
      start_run(1'b1, 2, 2, 1'b1);
      wait_done();

      // bad byte at index 2, address 3 never read
      mem[0] = 8'h03; mem[1] = 8'h41; mem[2] = 8'h1F; mem[3] = 8'h42;
      start_run(1'b0, 2, 2, 1'b1);
      wait_done();

      // inclusive bounds
      mem[0] = 8'h02; mem[1] = 8'h20; mem[2] = 8'h7E;
      start_run(1'b1, 2, 2, 1'b1);
      wait_done();

      mem[0] = 8'h01; mem[1] = 8'h7F;
      start_run(1'b0, 1, 1, 1'b1);
      wait_done();

      mem[0] = 8'h01; mem[1] = 8'h80;
      start_run(1'b0, 1, 1, 1'b1);
      wait_done();

      mem[0] = 8'h01; mem[1] = 8'h1F;
      start_run(1'b0, 1, 1, 1'b1);
      wait_done();

      // maximum length, then restart from DONE
      mem[0] = 8'hFF;
      for (int i = 1; i < 256; i++) mem[i] = 8'h41;
      start_run(1'b1, 255, 255, 1'b1);
      wait_done();
      start_run(1'b1, 255, 255, 1'b1);
      chk("restart_done_low", int'(done), 0);
      chk("restart_rdy_low", int'(rdy), 0);
      wait_done();

      // abort with reset mid-operation
      start_run(1'b0, 0, 0, 1'b0);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_rdy", int'(rdy), 1);
      chk("abort_done", int'(done), 0);
      chk("abort_addr", int'(pt_addr), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // fresh run with a busy-time en pulse that must be ignored
      mem[0] = 8'h03; mem[1] = 8'h41; mem[2] = 8'h42; mem[3] = 8'h43;
      start_run(1'b1, 3, 3, 1'b1);
      @(negedge clk);
      en = 1'b1;
      repeat (3) @(negedge clk);
      en = 1'b0;
      wait_done();

      repeat (4) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pt_validate.md
Name: pt_validate

Overview:
- Plaintext validator directly downstream of the ARC4 decrypt core in the task4 key-cracking design.
- After each candidate-key decryption, the crack controller starts this block. It reads the length-prefixed plaintext from the pt on-chip RAM and reports whether every message byte is printable ASCII.
- The controller uses `valid` to decide between latching the key for the HEX display and advancing to the next key.

Parameters:
- LO_CHAR, 8'h20, lowest accepted byte value (inclusive)
- HI_CHAR, 8'h7E, highest accepted byte value (inclusive)

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst_n  in  1  asynchronous active-low reset (driven from KEY[3])
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  idle and able to accept en
- pt_addr  out  8  pt RAM read address
- pt_rddata  in  8  pt RAM read data; synchronous RAM, data valid the cycle after the address is registered
- done  out  1  result available; held until next accepted en
- valid  out  1  1 = all bytes in [LO_CHAR, HI_CHAR]; meaningful only when done=1

Behaviour:
- Reset (async, rst_n=0) values:
  - rdy=1, done=0, valid=0, pt_addr=0, state=IDLE, byte counter=0.
  - Reset mid-operation aborts immediately to IDLE with no result.
- Handshake:
  - en && rdy at rising edge E0 = accept.
  - On accept: rdy=0, done=0, valid=0 from after E0.
  - en while rdy=0 is ignored and not queued.
  - rdy returns to 1 on the same edge done rises.
- Single-port read only; the block never writes pt RAM.
- States:
  - IDLE: rdy=1. On accept, go to RD_LEN with pt_addr=0.
  - RD_LEN: issue read of address 0. Next state WAIT_LEN.
  - WAIT_LEN: capture len=pt_rddata.
    - If len==0: go to DONE with valid=1.
    - Else: set idx=1, pt_addr=1, go to RD_BYTE.
  - RD_BYTE: hold pt_addr=idx. Next state WAIT_BYTE.
  - WAIT_BYTE: compare pt_rddata combinationally against the range.
    - If out of range: go to DONE with valid=0 (early exit).
    - Else if idx==len: go to DONE with valid=1.
    - Else: idx+1, pt_addr=idx+1, go to RD_BYTE.
  - DONE: done=1, rdy=1, valid held. Accepting en restarts at RD_LEN and clears done/valid.
- Timing:
  - All-valid message of length L: done rises after edge E0+2L+2 (L=0 gives E0+2).
  - First bad byte at index k: done rises after edge E0+2k+2.
  - Bytes after the first bad one are never read.
- Width rules:
  - idx is 8-bit; len max 255, so idx never wraps (idx==len terminates at 255).
  - The comparison is unsigned; both bounds are inclusive.
- pt_addr is registered and changes only on state-transition edges; it holds steady through each WAIT state.
- Simultaneous en and reset: reset wins.

Test Plan:
- pt = {00}; pulse en → done after E0+2, valid=1, pt_addr only ever 0.
- pt = {02, 48, 69} ("Hi") → addresses 0,1,2 read in order; done after E0+6, valid=1.
- pt = {03, 41, 1F, 42} → done after E0+6, valid=0; address 3 never driven.
- Boundaries:
  - pt = {02, 20, 7E} → valid=1.
  - pt = {01, 7F} → valid=0.
  - pt = {01, 80} → valid=0 (unsigned compare).
- pt = {FF, 255×41} → done after E0+512, valid=1; pt_addr reaches FF without wrapping. Then, with done=1, pulse en again → done drops the next cycle and the same result recurs.
- Start a 255-byte check, assert rst_n=0 at E0+10 → rdy=1, done=0, pt_addr=0 immediately. A fresh en then completes normally. A second en pulse held during busy has no effect on the timing.
